// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Stalls EX while iterating and writes {rem, quo} to HI/LO once per operation.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic               annul_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic               hilowrite_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ZERO = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               nega_q, nega_d;
    logic               negb_q, negb_d;
    logic               first_q, first_d;
    logic [2*WIDTH-1:0] res_q, res_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_n, quo_n;
    logic [WIDTH-1:0]   rem_fix, quo_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
            nega_q  <= 1'b0;
            negb_q  <= 1'b0;
            first_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
            nega_q  <= nega_d;
            negb_q  <= negb_d;
            first_q <= first_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i)
                    state_d = (opb_i == '0) ? S_ZERO : S_BUSY;
            end
            S_ZERO: state_d = annul_i ? S_IDLE : S_DONE;
            S_BUSY: begin
                if (annul_i)
                    state_d = S_IDLE;
                else if (cnt_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (annul_i || !start_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand conditioning and one restoring step per BUSY cycle
    always_comb begin
        a_neg   = signed_i & opa_i[WIDTH-1];
        b_neg   = signed_i & opb_i[WIDTH-1];
        a_mag   = a_neg ? -opa_i : opa_i;
        b_mag   = b_neg ? -opb_i : opb_i;
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_n   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                               : trial[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        quo_fix = (sgn_q && (nega_q ^ negb_q)) ? -quo_n : quo_n;
        rem_fix = (sgn_q && nega_q) ? -rem_n : rem_n;

        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
        nega_d  = nega_q;
        negb_d  = negb_q;
        first_d = 1'b0;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    sgn_d  = signed_i;
                    nega_d = a_neg;
                    negb_d = b_neg;
                    dvs_d  = b_mag;
                    cnt_d  = '0;
                    rem_d  = '0;
                    // divide-by-zero reports the untouched dividend
                    quo_d  = (opb_i == '0) ? opa_i : a_mag;
                end
            end
            S_ZERO: begin
                if (!annul_i) begin
                    res_d   = {quo_q, {WIDTH{1'b1}}};
                    first_d = 1'b1;
                end
            end
            S_BUSY: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (!annul_i && cnt_q == LAST) begin
                    res_d   = {rem_fix, quo_fix};
                    first_d = 1'b1;
                end
            end
            default: first_d = 1'b0;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        ready_o     = 1'b0;
        hilowrite_o = 1'b0;
        result_o    = res_q;
        unique case (state_q)
            S_IDLE:  stall_o = start_i & ~annul_i;
            S_ZERO:  stall_o = ~annul_i;
            S_BUSY:  stall_o = ~annul_i;
            S_DONE: begin
                ready_o     = 1'b1;
                hilowrite_o = first_q;
            end
            default: stall_o = 1'b0;
        endcase
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle sequencer for the DIV/DIVU path. It replaces a single-cycle combinational divider with a radix-2 restoring iteration.
- Accepts operands from the EX stage when the decoder flags a divide.
- Holds the pipeline via a stall request while it works.
- Delivers {hi=remainder, lo=quotient} with a HI/LO write strobe.
- Aborts cleanly on an exception flush.

Parameters:
WIDTH, 32, operand width; quotient/remainder each WIDTH bits; iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  EX holds a DIV/DIVU; level signal, held high by stalled pipeline
signed_i  input  1  1=DIV (two's complement), 0=DIVU; sampled with start
opa_i  input  WIDTH  dividend (rs value); sampled with start
opb_i  input  WIDTH  divisor (rt value); sampled with start
annul_i  input  1  exception/flush; aborts any operation in progress
stall_o  output  1  pipeline stall request
ready_o  output  1  result valid
hilowrite_o  output  1  one-cycle HI/LO write strobe
result_o  output  2*WIDTH  {remainder, quotient}

Behaviour:
- Reset is synchronous: rst high at a rising edge forces state IDLE, counter 0, internal regs 0. It has priority over all inputs, including mid-operation.
- Reset values: stall_o=0, ready_o=0, hilowrite_o=0, result_o=0.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - start_i=1 and annul_i=0: latch signed_i, |opa|, |opb|, and sign flags. Magnitudes are used only when signed_i=1; otherwise raw values.
  - Next state is ZERO if opb_i==0, else BUSY with counter=0 and partial remainder=0.
  - start_i=0 or annul_i=1: stay in IDLE.
- BUSY, one iteration per cycle:
  - {rem,quo} shifted left by 1.
  - trial = rem - divisor (WIDTH+1 bits).
  - If non-negative: rem=trial and quo LSB=1; else quo LSB=0.
  - counter increments. After iteration WIDTH (counter==WIDTH-1), go to DONE.
- Sign fix-up (signed only), applied when entering DONE:
  - quotient negated iff dividend and divisor signs differ.
  - remainder negated iff dividend negative.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 (wrap) and remainder 0; no trap.
- ZERO: one cycle, then DONE with quotient = all ones and remainder = original opa_i (unmodified). This is the team-defined value for the architecturally undefined divide-by-zero case.
- DONE:
  - ready_o=1 and result_o stable.
  - hilowrite_o=1 only on the first DONE cycle.
  - Stays in DONE while start_i=1; goes to IDLE when start_i=0. No restart is possible without start_i dropping.
- stall_o is combinational:
  - 1 when (IDLE & start_i & !annul_i), or state is ZERO or BUSY.
  - 0 in DONE, so the pipeline advances in the cycle result is valid.
- Latency, counting from the start-sample edge as cycle 0:
  - normal: BUSY occupies cycles 1..WIDTH; ready at cycle WIDTH+1 (33).
  - divide-by-zero: ready at cycle 2.
- annul_i=1 in ZERO, BUSY or DONE:
  - next state IDLE; ready_o and hilowrite_o are not asserted in that next cycle.
  - stall_o drops combinationally in the annul cycle.
  - result_o holds its last committed value.
- result_o updates only on entry to DONE; it holds otherwise, including through IDLE.
- Simultaneous annul_i and start_i in IDLE: annul wins and no operation starts.

Test Plan:
1. DIVU 100/7, start held until ready: stall_o=1 cycles 0..32; ready_o and hilowrite_o rise at cycle 33; result_o={0x00000002, 0x0000000E}. Drop start at 34: IDLE at 35, hilowrite_o asserted exactly once.
2. DIV -7/2 (0xFFFFFFF9/0x00000002): result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2: result_o={0x00000001, 0xFFFFFFFD}.
3. DIV 0x80000000/0xFFFFFFFF: result_o={0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/0x00000001: result_o={0x00000000, 0xFFFFFFFF}.
4. DIVU 0x1234/0: state ZERO at cycle 1, ready at cycle 2, result_o={0x00001234, 0xFFFFFFFF}.
5. annul_i pulsed at cycle 10 of a DIVU: stall_o=0 at cycle 10; IDLE at 11; ready_o and hilowrite_o never assert; result_o keeps its prior value. A new start at 12 completes normally at 45.
6. rst asserted at cycle 20 of a DIV: all outputs 0 and state IDLE on the next edge; start_i=1 and annul_i=1 together in IDLE leave stall_o=0 and the state IDLE.
